// File: rtl/serial_deser_if.sv
// Bit-serial input / word-parallel output bundle for serial_deser.
// master drives bits and accepts words; slave is the deserializer.
interface serial_deser_if #(
  parameter int WIDTH = 8
);
  logic             d;
  logic             d_en;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             overrun;
  logic             busy;

  modport master (
    output d, d_en, q_ready,
    input  q, q_valid, overrun, busy
  );

  modport slave (
    input  d, d_en, q_ready,
    output q, q_valid, overrun, busy
  );
endinterface

// File: rtl/serial_deser.sv
// MSB-first serial-to-parallel converter with a one-word output buffer
// and a sticky overrun flag for words dropped under backpressure.
module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  serial_deser_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_valid_reg, q_valid_next;
  logic             overrun_reg, overrun_next;
  logic             complete;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    shreg_next   = shreg_reg;
    q_next       = q_reg;
    q_valid_next = q_valid_reg;
    overrun_next = overrun_reg;
    complete     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.d_en) begin
          state_next = SHIFT;
          count_next = CW'(1);
          shreg_next = {{(WIDTH-1){1'b0}}, bus.d};
        end
      end
      SHIFT: begin
        if (bus.d_en) begin
          shreg_next = {shreg_reg[WIDTH-2:0], bus.d};
          if (count_reg == LAST) begin
            complete   = 1'b1;
            state_next = IDLE;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (q_valid_reg && bus.q_ready)
      q_valid_next = 1'b0;

    // A completed word replaces the buffer only if it is empty or being drained now.
    if (complete) begin
      if (!q_valid_reg || bus.q_ready) begin
        q_next       = shreg_next;
        q_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      shreg_reg   <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      shreg_reg   <= shreg_next;
      q_reg       <= q_next;
      q_valid_reg <= q_valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;
  assign bus.overrun = overrun_reg;
  assign bus.busy    = (state_reg == SHIFT);
endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser at WIDTH 8, 2 and 32 sharing one clock and reset.
module tb_serial_deser;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_deser_if #(.WIDTH(8))  bus8();
  serial_deser_if #(.WIDTH(2))  bus2();
  serial_deser_if #(.WIDTH(32)) bus32();

  serial_deser #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
  serial_deser #(.WIDTH(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));
  serial_deser #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bit8(input logic b);
    bus8.d = b;
    bus8.d_en = 1'b1;
    tick();
  endtask

  task automatic idle8();
    bus8.d_en = 1'b0;
    bus8.d = 1'bx;
    tick();
  endtask

  logic [7:0]  w8;
  logic [31:0] w32;
  logic [3:0]  b2;

  initial begin
    bus8.d = 1'b0;  bus8.d_en = 1'b0;  bus8.q_ready = 1'b1;
    bus2.d = 1'b0;  bus2.d_en = 1'b0;  bus2.q_ready = 1'b1;
    bus32.d = 1'b0; bus32.d_en = 1'b0; bus32.q_ready = 1'b1;

    // Reset state
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rst_q",        {24'd0, bus8.q}, 32'h0);
    chk("rst_q_valid",  {31'd0, bus8.q_valid}, 32'h0);
    chk("rst_overrun",  {31'd0, bus8.overrun}, 32'h0);
    chk("rst_busy",     {31'd0, bus8.busy}, 32'h0);
    chk("rst_busy32",   {31'd0, bus32.busy}, 32'h0);
    chk("rst_q2",       {30'd0, bus2.q}, 32'h0);

    // Basic word; first bit is taken on the very first edge out of reset
    reset = 1'b1;
    w8 = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      bit8(w8[i]);
      if (i == 7) chk("basic_busy1", {31'd0, bus8.busy}, 32'h1);
      if (i == 1) chk("basic_nv7",   {31'd0, bus8.q_valid}, 32'h0);
    end
    chk("basic_q",       {24'd0, bus8.q}, 32'hB2);
    chk("basic_valid",   {31'd0, bus8.q_valid}, 32'h1);
    chk("basic_busy0",   {31'd0, bus8.busy}, 32'h0);
    chk("basic_overrun", {31'd0, bus8.overrun}, 32'h0);
    idle8();
    chk("basic_valid_1cy", {31'd0, bus8.q_valid}, 32'h0);
    chk("basic_q_hold",    {24'd0, bus8.q}, 32'hB2);

    // Stall after bit 4 with d toggling while d_en=0
    for (int i = 7; i >= 4; i--) bit8(w8[i]);
    for (int s = 0; s < 3; s++) begin
      bus8.d_en = 1'b0;
      bus8.d = s[0];
      tick();
      chk("stall_busy",  {31'd0, bus8.busy}, 32'h1);
      chk("stall_valid", {31'd0, bus8.q_valid}, 32'h0);
    end
    for (int i = 3; i >= 0; i--) bit8(w8[i]);
    chk("stall_q",     {24'd0, bus8.q}, 32'hB2);
    chk("stall_valid", {31'd0, bus8.q_valid}, 32'h1);
    idle8();

    // Back-to-back A5 then 3C under backpressure
    bus8.q_ready = 1'b0;
    w8 = 8'hA5;
    for (int i = 7; i >= 0; i--) bit8(w8[i]);
    chk("bp_q1",     {24'd0, bus8.q}, 32'hA5);
    chk("bp_valid1", {31'd0, bus8.q_valid}, 32'h1);
    w8 = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      bit8(w8[i]);
      chk("bp_q_hold", {24'd0, bus8.q}, 32'hA5);
    end
    chk("bp_valid2",  {31'd0, bus8.q_valid}, 32'h1);
    chk("bp_overrun", {31'd0, bus8.overrun}, 32'h1);
    bus8.q_ready = 1'b1;
    idle8();
    chk("bp_drain_valid", {31'd0, bus8.q_valid}, 32'h0);
    chk("bp_drain_q",     {24'd0, bus8.q}, 32'hA5);
    idle8();
    chk("bp_sticky",      {31'd0, bus8.overrun}, 32'h1);

    // Reset clears overrun; then accept and complete on the same edge
    reset = 1'b0;
    tick(); tick();
    chk("rst2_overrun", {31'd0, bus8.overrun}, 32'h0);
    reset = 1'b1;
    bus8.q_ready = 1'b0;
    w8 = 8'hA5;
    for (int i = 7; i >= 0; i--) bit8(w8[i]);
    chk("sim_q1", {24'd0, bus8.q}, 32'hA5);
    w8 = 8'h3C;
    for (int i = 7; i >= 1; i--) bit8(w8[i]);
    bus8.q_ready = 1'b1;
    bit8(w8[0]);
    chk("sim_q2",      {24'd0, bus8.q}, 32'h3C);
    chk("sim_valid",   {31'd0, bus8.q_valid}, 32'h1);
    chk("sim_overrun", {31'd0, bus8.overrun}, 32'h0);
    idle8();
    chk("sim_drain",   {31'd0, bus8.q_valid}, 32'h0);

    // Reset mid-word, with d_en still high during reset
    for (int i = 0; i < 5; i++) bit8(1'b1);
    chk("mid_busy", {31'd0, bus8.busy}, 32'h1);
    reset = 1'b0;
    bus8.d = 1'b1;
    bus8.d_en = 1'b1;
    tick();
    chk("mid_busy0",  {31'd0, bus8.busy}, 32'h0);
    chk("mid_valid0", {31'd0, bus8.q_valid}, 32'h0);
    chk("mid_q0",     {24'd0, bus8.q}, 32'h0);
    reset = 1'b1;
    w8 = 8'h0F;
    for (int i = 7; i >= 0; i--) begin
      bit8(w8[i]);
      if (i != 0) chk("mid_nv", {31'd0, bus8.q_valid}, 32'h0);
    end
    chk("mid_q",       {24'd0, bus8.q}, 32'h0F);
    chk("mid_valid",   {31'd0, bus8.q_valid}, 32'h1);
    chk("mid_overrun", {31'd0, bus8.overrun}, 32'h0);
    idle8();

    // WIDTH=2: bits 1,1,0,1 continuously
    b2 = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      bus2.d = b2[i];
      bus2.d_en = 1'b1;
      tick();
      if (i == 2) begin
        chk("w2_q1", {30'd0, bus2.q}, 32'h3);
        chk("w2_v1", {31'd0, bus2.q_valid}, 32'h1);
      end
      if (i == 1) chk("w2_v_gap", {31'd0, bus2.q_valid}, 32'h0);
    end
    chk("w2_q2", {30'd0, bus2.q}, 32'h1);
    chk("w2_v2", {31'd0, bus2.q_valid}, 32'h1);
    bus2.d_en = 1'b0;
    tick();
    chk("w2_drain", {31'd0, bus2.q_valid}, 32'h0);

    // WIDTH=32 basic word
    w32 = 32'hDEADBEEF;
    for (int i = 31; i >= 0; i--) begin
      bus32.d = w32[i];
      bus32.d_en = 1'b1;
      tick();
      if (i == 1) chk("w32_nv", {31'd0, bus32.q_valid}, 32'h0);
    end
    chk("w32_q",       bus32.q, 32'hDEADBEEF);
    chk("w32_valid",   {31'd0, bus32.q_valid}, 32'h1);
    chk("w32_overrun", {31'd0, bus32.overrun}, 32'h0);
    bus32.d_en = 1'b0;
    tick();
    chk("w32_drain",   {31'd0, bus32.q_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
